// File: rtl/arith_pkg.sv
// arith_pkg: shared helpers and stage register type for the pipelined adder
`ifndef ARITH_PKG_SV
`define ARITH_PKG_SV
`define ARITH_STAGE_T(W) struct packed { logic valid; logic [(W)-1:0] psum; logic carry; logic c_msb_in; logic [(W)-1:0] a_hi; logic [(W)-1:0] b_hi; }
package arith_pkg;
  function automatic bit stages_ok(int unsigned w, int unsigned s);
    return w >= 2 && s >= 1 && w % s == 0;
  endfunction
  function automatic int unsigned seg_w(int unsigned w, int unsigned s);
    return s == 0 ? w : w / s;
  endfunction
endpackage
`endif

// File: rtl/pipelined_adder_ha_cell.sv
// ha_cell: 1-bit half adder
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder with STAGES registered carry segments and valid/ready on both sides
module pipelined_adder
  import arith_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SEG = seg_w(WIDTH, STAGES);
  typedef `ARITH_STAGE_T(WIDTH) stage_t;
  if (!stages_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be >= 2 and divisible by STAGES");
  end
  logic [STAGES-1:0] vld;
  logic [STAGES:0]   adv;
  assign adv[STAGES] = out_ready;
  assign in_ready    = adv[0];
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           st_d, st_q;
    logic [WIDTH-1:0] a_src, b_src, p_src;
    logic             c_src, v_src;
    logic [SEG-1:0]   s;
    if (k == 0) begin : g_first
      assign v_src = in_valid;
      assign a_src = a;
      assign b_src = b;
      assign c_src = cin;
      assign p_src = '0;
    end else begin : g_next
      assign v_src = g_stage[k-1].st_q.valid;
      assign a_src = g_stage[k-1].st_q.a_hi;
      assign b_src = g_stage[k-1].st_q.b_hi;
      assign c_src = g_stage[k-1].st_q.carry;
      assign p_src = g_stage[k-1].st_q.psum;
    end
    // a_hi/b_hi hold the not-yet-summed operand bits shifted down to bit 0
    for (genvar i = 0; i < SEG; i++) begin : g_bit
      logic ci, co, s1, c1, c2;
      if (i == 0) begin : g_cin
        assign ci = c_src;
      end else begin : g_cchain
        assign ci = g_bit[i-1].co;
      end
      ha_cell u_ha0 (.a(a_src[i]), .b(b_src[i]), .s(s1),   .c(c1));
      ha_cell u_ha1 (.a(s1),       .b(ci),       .s(s[i]), .c(c2));
      assign co = c1 | c2;
    end
    always_comb begin
      st_d.valid    = v_src;
      st_d.psum     = p_src | (WIDTH'(s) << (SEG * k));
      st_d.carry    = g_bit[SEG-1].co;
      st_d.c_msb_in = g_bit[SEG-1].ci;
      st_d.a_hi     = a_src >> SEG;
      st_d.b_hi     = b_src >> SEG;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) st_q <= '0;
      else if (adv[k]) st_q <= st_d;
    end
    assign vld[k] = st_q.valid;
    // a stage may advance if it or any later stage holds a bubble
    assign adv[k] = out_ready || !(&vld[STAGES-1:k]);
  end
  assign out_valid = g_stage[STAGES-1].st_q.valid;
  assign sum       = g_stage[STAGES-1].st_q.psum;
  assign cout      = g_stage[STAGES-1].st_q.carry;
  assign ovf       = g_stage[STAGES-1].st_q.carry ^ g_stage[STAGES-1].st_q.c_msb_in;
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder built from a chain of half-adder cells.
- It is the multi-bit, clocked successor to the single-bit half adder in the arithmetic library.
- The carry chain is split into STAGES registered segments, so throughput is one add per cycle at higher clock rates.
- Valid/ready handshakes on both ports allow it to drop into streaming datapaths, such as accumulators and ALU front-ends.

Parameters:
- WIDTH, 8: operand/sum width in bits; must be at least 2.
- STAGES, 2: number of pipeline segments; must divide WIDTH exactly; SEG = WIDTH/STAGES bits are summed per stage.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands a, b, cin valid this cycle
- in_ready  out  1  block accepts input when in_valid && in_ready
- a  in  WIDTH  operand A (unsigned or two's complement)
- b  in  WIDTH  operand B
- cin  in  1  carry in
- out_valid  out  1  sum, cout, ovf valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- sum  out  WIDTH  (a+b+cin) mod 2^WIDTH
- cout  out  1  unsigned carry out of the MSB
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, active-high):
  - All stage valid bits, out_valid, sum, cout and ovf clear to 0 immediately.
  - in_ready = 1 as soon as rst deasserts.
  - Reset mid-operation discards all in-flight operations; no output is produced for them.
- Stage k (k = 0..STAGES-1) register contents:
  - valid_k;
  - partial sum bits [SEG*(k+1)-1:0];
  - carry out of bit SEG*(k+1)-1;
  - unprocessed high slices of a and b;
  - carry into bit SEG*(k+1)-1, used for ovf at the last stage.
- Per-stage arithmetic:
  - Each bit is a full-add formed from two ha_cell instances plus an OR.
  - Stage 0 uses cin. Stage k>0 uses the registered carry of stage k-1.
- Latency:
  - An accepted input appears on the outputs exactly STAGES cycles later, provided there is no stall.
  - Throughput is 1 per cycle.
  - Output registers are the stage STAGES-1 registers.
- Advance rule:
  - adv_k = !valid_k || adv_{k+1}, with adv_STAGES = out_ready.
  - in_ready = adv_0, which is combinational from out_ready through the chain.
  - A stage whose adv is 0 holds all of its contents.
- Bubbles: an empty stage accepts new data even while downstream stages are stalled (bubble collapse).
- Output stability: while out_valid && !out_ready, sum/cout/ovf/out_valid must hold stable.
- Simultaneous accept and emit in the same cycle is legal; a full pipeline with out_ready=1 streams without a gap.
- in_valid while !in_ready: the input is ignored, not lost state; the upstream source must hold it.
- Wrap-around examples: a=b=all-ones, cin=1 gives sum=all-ones, cout=1.
- Degenerate case: STAGES=1 is legal and gives a single registered stage with latency 1.
- Illegal parameter combinations (WIDTH % STAGES != 0, or WIDTH < 2) are an elaboration error.

Decomposition:
- Shared package arith_pkg holds:
  - a function checking WIDTH % STAGES == 0;
  - the SEG localparam helper;
  - a struct type for the stage register (valid, psum, carry, c_msb_in, a_hi, b_hi), parameterised by width via a macro or generate.
- One natural sub-module, ha_cell: a 1-bit half adder with inputs a, b and outputs s, c. Two instances plus an OR form each full-add bit.
- Stage logic is generated in a for-generate loop; there is no separate stage module.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: a=8'h3C, b=8'h0F, cin=0 accepted at cycle 0 -> cycle 2: out_valid=1, sum=8'h4B, cout=0, ovf=0.
- a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1, ovf=0. Separately, a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- Back-to-back streaming:
  - 16 random operand pairs on consecutive cycles, out_ready=1.
  - Required: 16 results on consecutive cycles from cycle 2, each matching a reference model; in_ready never drops.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1.
  - Required: in_ready drops after the 2 stages fill; sum stays stable; no result is lost or duplicated after out_ready returns to 1.
- Bubble collapse:
  - Gap of 1 cycle in in_valid, then out_ready=0 for 1 cycle.
  - Required: the bubble is absorbed, and in_ready remains 1 while any stage is empty.
- Reset mid-operation:
  - Assert rst asynchronously, between clock edges, with 2 operations in flight.
  - Required: out_valid=0 and sum=0 immediately; after release, no stale results appear, and a new op a=1, b=1 yields sum=2 at latency 2.
